// File: rtl/multdiv_sequencer.sv
// Sequencer for the multi-cycle mult/div unit: latch, start pulse, stall, writeback.
// Optional BUSY watchdog enabled by defining MULTDIV_WATCHDOG_EN.
module multdiv_sequencer #(
  parameter int RSTATUS_REG   = 30,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5,
  parameter int MAX_CYCLES    = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        flush,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [4:0]  dest_in,
  input  logic [31:0] mdu_result,
  input  logic        mdu_exception,
  input  logic        mdu_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] mdu_opA,
  output logic [31:0] mdu_opB,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dest,
  output logic [6:0]  busy_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

`ifdef MULTDIV_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [6:0] WD_LIMIT = 7'(MAX_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  dest_q, dest_d;
  logic        is_div_q, is_div_d;
  logic        ctrl_q, ctrl_d;
  logic [6:0]  busy_q, busy_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic req;
  logic wd_hit;

  assign req    = start_mult | start_div;
  assign wd_hit = WD_EN && (busy_q == WD_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      dest_q   <= '0;
      is_div_q <= 1'b0;
      ctrl_q   <= 1'b0;
      busy_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      dest_q   <= dest_d;
      is_div_q <= is_div_d;
      ctrl_q   <= ctrl_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    dest_d   = dest_q;
    is_div_d = is_div_q;
    ctrl_d   = 1'b0;
    busy_d   = busy_q;
    result_d = result_q;
    exc_d    = exc_q;
    unique case (state_q)
      IDLE: begin
        if (req && !flush) begin
          state_d  = BUSY;
          opa_d    = operandA;
          opb_d    = operandB;
          dest_d   = dest_in;
          is_div_d = !start_mult;
          ctrl_d   = 1'b1;
          busy_d   = '0;
        end
      end
      BUSY: begin
        if (busy_q != 7'h7f) busy_d = busy_q + 7'd1;
        // ctrl_q marks the pulse cycle, where RDY cannot be genuine
        if (flush) begin
          state_d = IDLE;
        end else if (mdu_resultRDY && !ctrl_q) begin
          state_d  = DONE;
          result_d = mdu_result;
          exc_d    = mdu_exception;
        end else if (wd_hit) begin
          state_d  = DONE;
          result_d = '0;
          exc_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ctrl_MULT   = ctrl_q & ~is_div_q;
  assign ctrl_DIV    = ctrl_q & is_div_q;
  assign mdu_opA     = opa_q;
  assign mdu_opB     = opb_q;
  assign busy_cycles = busy_q;
  assign stall       = !reset &&
                       ((state_q == IDLE && req && !flush) ||
                        state_q == BUSY);
  assign wb_valid    = (state_q == DONE);

  always_comb begin
    wb_data = '0;
    wb_dest = '0;
    if (wb_valid) begin
      if (exc_q) begin
        wb_dest = 5'(RSTATUS_REG);
        wb_data = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
      end else begin
        wb_dest = dest_q;
        wb_data = result_q;
      end
    end
  end

endmodule
